// File: rtl/brq_pkg.sv
// Shared types and constants for the brq instruction-fetch front end.
package brq_pkg;

  typedef enum logic [1:0] {
    PF_IDLE = 2'd0,
    PF_REQ  = 2'd1,
    PF_HOLD = 2'd2
  } pf_state_e;

  localparam logic [31:0] PF_WORD_INC = 32'd4;

  // Bus fetches are always word aligned, even for halfword branch targets.
  function automatic logic [31:0] pf_word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/brq_ifu_prefetch_ctrl_if.sv
// Instruction-memory request/response port between the prefetch controller and memory.
interface brq_ifu_prefetch_ctrl_if;

  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, err);

endinterface

// File: rtl/brq_ifu_outstanding_tracker.sv
// Counts in-flight bus requests and remembers, per request in issue order, whether
// its response must be dropped. Entry 0 of the discard vector is the oldest request.
module brq_ifu_outstanding_tracker #(
  parameter  int unsigned NUM_REQS = 2,
  localparam int unsigned CNT_W    = $clog2(NUM_REQS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             oldest_discard
);

  logic [NUM_REQS-1:0] discard_q;
  logic [NUM_REQS-1:0] discard_d;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic [CNT_W-1:0]    tail;

  // NOTE: every variable gets a default first so no path through this block infers a latch.
  always_comb begin
    discard_d = discard_q;
    tail      = count_q;
    if (pop) begin
      discard_d = discard_q >> 1;
      tail      = count_q - CNT_W'(1);
    end
    // A flush also covers a request granted in the same cycle.
    if (flush) discard_d = '1;
    if (push) begin
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
        if (tail == CNT_W'(i)) discard_d[i] = flush;
      end
    end
    count_d = tail + CNT_W'(push);
  end

  // NOTE: registers update with <= so every flop samples the pre-edge values of its inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= '0;
      // NOTE: discard bits are reset as well; stale flags must not survive into a fresh run.
      discard_q <= '0;
    end else begin
      count_q   <= count_d;
      discard_q <= discard_d;
    end
  end

  assign count          = count_q;
  assign oldest_discard = discard_q[0];

endmodule

// File: rtl/brq_ifu_prefetch_ctrl.sv
// Prefetch controller: issues word-aligned instruction fetches into brq_fetch_fifo,
// drops branch-stale responses and never overfills the FIFO.
// Optional macro BRQ_IFU_PREFETCH_PERF_EN adds stall and discard performance outputs.
module brq_ifu_prefetch_ctrl
  import brq_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    branch_i,
  input  logic [31:0]             addr_i,
  output logic                    busy_o,
  brq_ifu_prefetch_ctrl_if.master instr_bus,
  output logic                    fifo_clear_o,
  input  logic [NUM_REQS-1:0]     fifo_busy_i,
  output logic                    fifo_valid_o,
  output logic [31:0]             fifo_addr_o,
  output logic [31:0]             fifo_rdata_o,
  output logic                    fifo_err_o
`ifdef BRQ_IFU_PREFETCH_PERF_EN
  ,
  output logic                    perf_stall_o,
  output logic [15:0]             perf_discard_cnt_o
`endif
);

  localparam int unsigned CNT_W = $clog2(NUM_REQS + 1);

  pf_state_e        state_q, state_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic [31:0]      hold_addr_q;
  logic             hold_load;
  logic [CNT_W-1:0] outstanding;
  logic             oldest_discard;
  logic             gnt, rsp, drop, flush;
  logic             room, room_branch, room_sel;
  int unsigned      fifo_occ;

  assign gnt  = instr_bus.req & instr_bus.gnt;
  assign rsp  = instr_bus.rvalid & (outstanding != '0);
  assign drop = oldest_discard | branch_i;
  // A grant out of HOLD is the old-address request, so it is born stale.
  assign flush = branch_i | (gnt & (state_q == PF_HOLD));

  brq_ifu_outstanding_tracker #(
    .NUM_REQS(NUM_REQS)
  ) u_tracker (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push          (gnt),
    .pop           (rsp),
    .flush         (flush),
    .count         (outstanding),
    .oldest_discard(oldest_discard)
  );

  always_comb begin
    fifo_occ = 0;
    for (int unsigned i = 0; i < NUM_REQS; i++) fifo_occ += 32'(fifo_busy_i[i]);
  end

  // On a branch the FIFO is being cleared, so only in-flight requests consume room.
  assign room        = (fifo_occ + 32'(outstanding) + 32'(gnt)) < NUM_REQS;
  assign room_branch = (32'(outstanding) + 32'(gnt)) < NUM_REQS;
  assign room_sel    = branch_i ? room_branch : room;
  assign hold_load   = (state_q == PF_REQ) & branch_i & ~gnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= PF_IDLE;
      fetch_addr_q <= '0;
      hold_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      if (hold_load) hold_addr_q <= fetch_addr_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    unique case (state_q)
      PF_IDLE: if (req_i && room_sel) state_d = PF_REQ;
      PF_REQ: begin
        if (gnt)           state_d = (req_i && room_sel) ? PF_REQ : PF_IDLE;
        else if (branch_i) state_d = PF_HOLD;
      end
      PF_HOLD: if (gnt) state_d = (req_i && room_sel) ? PF_REQ : PF_IDLE;
      default: state_d = PF_IDLE;
    endcase
    if (branch_i)                          fetch_addr_d = pf_word_align(addr_i);
    else if (gnt && (state_q == PF_REQ))   fetch_addr_d = fetch_addr_q + PF_WORD_INC;
  end

  always_comb begin
    instr_bus.req  = (state_q != PF_IDLE);
    instr_bus.addr = (state_q == PF_HOLD) ? hold_addr_q : fetch_addr_q;
  end

  assign busy_o       = (outstanding != '0) | instr_bus.req;
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_valid_o = rsp & ~drop;
  assign fifo_rdata_o = instr_bus.rdata;
  assign fifo_err_o   = instr_bus.err;

`ifdef BRQ_IFU_PREFETCH_PERF_EN
  logic [15:0] discard_cnt_q;

  assign perf_stall_o = req_i & ~room & (state_q != PF_REQ);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      discard_cnt_q <= '0;
    end else if (rsp && drop && (discard_cnt_q != 16'hFFFF)) begin
      discard_cnt_q <= discard_cnt_q + 16'd1;
    end
  end

  assign perf_discard_cnt_o = discard_cnt_q;
`endif

endmodule

// File: tb/tb_brq_ifu_prefetch_ctrl.sv
// Self-checking bench for brq_ifu_prefetch_ctrl: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, simple in-order memory responder.
module tb_brq_ifu_prefetch_ctrl;

  localparam int unsigned NUM_REQS = 2;
  localparam logic [31:0] DATA_KEY = 32'h5A5A_0000;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req = 1'b0;
  logic                branch = 1'b0;
  logic [31:0]         baddr = '0;
  logic [NUM_REQS-1:0] fifo_busy = '0;
  logic                busy, fifo_clear, fifo_valid, fifo_err;
  logic [31:0]         fifo_addr, fifo_rdata;
`ifdef BRQ_IFU_PREFETCH_PERF_EN
  logic                perf_stall;
  logic [15:0]         perf_discard_cnt;
`endif

  bit gnt_en = 1'b0;
  bit rsp_en = 1'b0;
  bit err_en = 1'b0;
  bit chk_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] gq[$];
  logic [31:0] grant_log[$];
  logic [31:0] push_log[$];
  bit          push_err_log[$];

  // Reference model: pending request, next fetch address, in-flight discard flags.
  bit          m_pend = 1'b0;
  bit          m_stale = 1'b0;
  logic [31:0] m_paddr = '0;
  logic [31:0] m_next = '0;
  bit          mq[$];

  brq_ifu_prefetch_ctrl_if bus ();

  assign bus.gnt = gnt_en;

  brq_ifu_prefetch_ctrl #(
    .NUM_REQS(NUM_REQS)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .branch_i    (branch),
    .addr_i      (baddr),
    .busy_o      (busy),
    .instr_bus   (bus.master),
    .fifo_clear_o(fifo_clear),
    .fifo_busy_i (fifo_busy),
    .fifo_valid_o(fifo_valid),
    .fifo_addr_o (fifo_addr),
    .fifo_rdata_o(fifo_rdata),
    .fifo_err_o  (fifo_err)
`ifdef BRQ_IFU_PREFETCH_PERF_EN
    ,
    .perf_stall_o      (perf_stall),
    .perf_discard_cnt_o(perf_discard_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] glog(input int i);
    return (i < grant_log.size()) ? grant_log[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] plog(input int i);
    return (i < push_log.size()) ? push_log[i] : 32'hFFFF_FFFF;
  endfunction

  // Memory responder: in order, at least one cycle after the grant.
  always @(posedge clk) begin
    #2;
    if (rsp_en && gq.size() > 0) begin
      bus.rvalid = 1'b1;
      bus.rdata  = gq.pop_front() ^ DATA_KEY;
      bus.err    = err_en;
    end else begin
      bus.rvalid = 1'b0;
      bus.rdata  = 32'hDEAD_BEEF;
      bus.err    = 1'b0;
    end
  end

  always @(negedge clk) begin : model
    int unsigned n0;
    bit          g, room, room_br, exp_valid;
    logic [31:0] nxt;
    n0        = mq.size();
    g         = m_pend && (bus.gnt === 1'b1);
    exp_valid = (bus.rvalid === 1'b1) && (n0 > 0) && !mq[0] && !branch;
    if (chk_en) begin
      check("instr_req", 32'(bus.req), 32'(m_pend));
      if (m_pend) check("instr_addr", bus.addr, m_paddr);
      check("busy", 32'(busy), 32'((n0 != 0) || m_pend));
      check("fifo_clear", 32'(fifo_clear), 32'(branch));
      if (branch) check("fifo_addr", fifo_addr, baddr);
      check("fifo_valid", 32'(fifo_valid), 32'(exp_valid));
      if (exp_valid) begin
        check("fifo_rdata", fifo_rdata, bus.rdata);
        check("fifo_err", 32'(fifo_err), 32'(bus.err));
      end
      n_checks++;
      assert (dut.outstanding <= NUM_REQS)
      else begin
        n_errors++;
        $display("FAIL outstanding_bound: got %0d allowed %0d", dut.outstanding, NUM_REQS);
      end
    end
    if (fifo_valid === 1'b1) begin
      push_log.push_back(fifo_rdata);
      push_err_log.push_back(fifo_err);
    end
    if (bus.req === 1'b1 && bus.gnt === 1'b1) begin
      grant_log.push_back(bus.addr);
      gq.push_back(bus.addr);
    end
    if (rst) begin
      mq.delete();
      m_pend  = 1'b0;
      m_stale = 1'b0;
      m_paddr = '0;
      m_next  = '0;
    end else begin
      room    = (32'($countones(fifo_busy)) + n0 + 32'(g)) < NUM_REQS;
      room_br = (n0 + 32'(g)) < NUM_REQS;
      if (bus.rvalid === 1'b1 && n0 > 0) void'(mq.pop_front());
      if (g) mq.push_back(m_stale || branch);
      if (branch) foreach (mq[i]) mq[i] = 1'b1;
      nxt = m_next;
      if (branch)             nxt = {baddr[31:2], 2'b00};
      else if (g && !m_stale) nxt = m_next + 32'd4;
      if (m_pend && !g) begin
        if (branch) m_stale = 1'b1;
      end else if (req && (branch ? room_br : room)) begin
        m_pend  = 1'b1;
        m_paddr = nxt;
        m_stale = 1'b0;
      end else begin
        m_pend = 1'b0;
      end
      m_next = nxt;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_grants(input int target, input string tag);
    int k = 0;
    while (grant_log.size() < target && k < 50) begin
      tick();
      k++;
    end
    check({tag, "_grant_wait"}, 32'(grant_log.size() >= target), 32'd1);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    req    = 1'b0;
    branch = 1'b0;
    gnt_en = 1'b1;
    rsp_en = 1'b1;
    while ((busy !== 1'b0 || gq.size() != 0) && k < 50) begin
      tick();
      k++;
    end
    check({tag, "_drain"}, 32'(busy === 1'b0 && gq.size() == 0), 32'd1);
  endtask

  initial begin
    int g0, g1, p0, n_err;

    // Reset
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_valid", 32'(fifo_valid), 32'd0);
    check("rst_clear", 32'(fifo_clear), 32'd0);

    // 1: branch to 0x100, grant every cycle, respond one cycle later
    g0 = grant_log.size();
    p0 = push_log.size();
    gnt_en = 1'b1;
    rsp_en = 1'b1;
    req    = 1'b1;
    branch = 1'b1;
    baddr  = 32'h0000_0100;
    tick();
    branch = 1'b0;
    tick(8);
    drain("t1");
    check("t1_addr0", glog(g0), 32'h0000_0100);
    check("t1_addr1", glog(g0 + 1), 32'h0000_0104);
    check("t1_first_push", plog(p0), 32'h5A5A_0100);

    // 2: full FIFO blocks requests; one free slot allows exactly one
    g0 = grant_log.size();
    fifo_busy = 2'b11;
    rsp_en = 1'b0;
    req    = 1'b1;
    tick(4);
    check("t2_blocked", 32'(grant_log.size() - g0), 32'd0);
    check("t2_req_low", 32'(bus.req), 32'd0);
    fifo_busy = 2'b01;
    tick(5);
    check("t2_one_grant", 32'(grant_log.size() - g0), 32'd1);
    fifo_busy = '0;
    drain("t2");

    // 3: branch with two requests in flight, responses start in the branch cycle
    g0 = grant_log.size();
    req    = 1'b1;
    rsp_en = 1'b0;
    wait_grants(g0 + 2, "t3");
    tick(2);
    g1 = grant_log.size();
    p0 = push_log.size();
    check("t3_two_out", 32'(g1 - g0), 32'd2);
    branch = 1'b1;
    baddr  = 32'h0000_0202;
    rsp_en = 1'b1;
    #1;
    check("t3_clear", 32'(fifo_clear), 32'd1);
    check("t3_fifo_addr", fifo_addr, 32'h0000_0202);
    tick();
    branch = 1'b0;
    tick(6);
    check("t3_next_addr", glog(g1), 32'h0000_0200);
    check("t3_first_push", plog(p0), 32'h5A5A_0200);
    drain("t3");

    // 4: branch while a request at 0x108 waits for its grant
    g0 = grant_log.size();
    req    = 1'b1;
    branch = 1'b1;
    baddr  = 32'h0000_0100;
    tick();
    branch = 1'b0;
    wait_grants(g0 + 2, "t4");
    gnt_en = 1'b0;
    tick(2);
    g1 = grant_log.size();
    p0 = push_log.size();
    branch = 1'b1;
    baddr  = 32'h0000_0400;
    tick();
    branch = 1'b0;
    tick(3);
    check("t4_hold_req", 32'(bus.req), 32'd1);
    check("t4_hold_addr", bus.addr, 32'h0000_0108);
    gnt_en = 1'b1;
    tick(6);
    check("t4_grant_old", glog(g1), 32'h0000_0108);
    check("t4_grant_new", glog(g1 + 1), 32'h0000_0400);
    check("t4_first_push", plog(p0), 32'h5A5A_0400);
    drain("t4");

    // 5: error responses are pushed and fetching carries on
    g0 = grant_log.size();
    p0 = push_log.size();
    err_en = 1'b1;
    req    = 1'b1;
    tick(8);
    drain("t5");
    err_en = 1'b0;
    n_err  = 0;
    for (int i = p0; i < push_err_log.size(); i++) n_err += int'(push_err_log[i]);
    check("t5_err_pushed", 32'(n_err > 0), 32'd1);
    check("t5_step0", glog(g0 + 1) - glog(g0), 32'd4);
    check("t5_step1", glog(g0 + 2) - glog(g0 + 1), 32'd4);

    // 6: reset with two requests in flight; their late responses must not push
    g0 = grant_log.size();
    req    = 1'b1;
    rsp_en = 1'b0;
    wait_grants(g0 + 2, "t6");
    tick();
    req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_req", 32'(bus.req), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_valid", 32'(fifo_valid), 32'd0);
    p0 = push_log.size();
    rsp_en = 1'b1;
    tick(4);
    check("t6_ignored", 32'(push_log.size() - p0), 32'd0);
    drain("t6");

    tick(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
